spu_wen_mt: RTL and testbench

- Multi-thread, parametrised write-enable and store-ack tracking block for the SPU modular-arithmetic (MA) unit.
- Generates, per thread, the MA line write enables, MA line valid bits and load/store ack qualifiers.
- Captures L2 error status per thread.
- Keeps a saturating outstanding-store counter per thread.
- Builds the PCX request header with the requesting thread ID inserted.
- Sits between the MA load/store control and the LSU return/ack interface.

---
 rtl/spu_wen_mt.sv | 159 +++++++++++++++
 tb/tb_spu_wen_mt.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_wen_mt.sv
// Per-thread MA line write enables, error capture, load/store ack qualifiers and store counters.
// Latency: maln_wen/acks/pckt_req combinational; vld_maln and errors one cycle; counters three cycles after the request.
// Backpressure: none; every input is sampled each cycle and the block never stalls its neighbours.
module spu_wen_mt #(
    parameter int NTHR = 4,
    parameter int CNTW = 6
) (
    input  logic               rclk,
    input  logic               reset,
    input  logic               se,
    input  logic [2:0]         cpuid,
    input  logic               spu_mald_ldreq,
    input  logic               spu_mactl_streq,
    input  logic [1:0]         spu_req_tid,
    input  logic               lsu_spu_vload_vld,
    input  logic [3:0]         lsu_spu_vload_rtntyp,
    input  logic [1:0]         lsu_spu_vload_tid,
    input  logic [1:0]         l2_err,
    input  logic               lsu_spu_st_ackvld,
    input  logic               lsu_spu_st_asop,
    input  logic [1:0]         lsu_spu_st_ack_tid,
    input  logic               lsu_spu_ld_ackvld,
    input  logic               lsu_spu_ld_asop,
    input  logic [1:0]         lsu_spu_ld_ack_tid,
    input  logic [1:0]         lsu_spu_strm_ack_cmplt,
    input  logic [1:0]         lsu_spu_strm_ack_tid,
    input  logic [NTHR-1:0]    spu_mald_done,
    input  logic [NTHR-1:0]    spu_mald_rstln,
    input  logic [NTHR-1:0]    spu_mactl_uncerr_rst,
    output logic [NTHR-1:0]    spu_wen_maln_wen,
    output logic [NTHR-1:0]    spu_wen_vld_maln,
    output logic [NTHR-1:0]    spu_wen_mast_ack,
    output logic [NTHR-1:0]    spu_wen_mald_ack,
    output logic               spu_wen_ldst_pcx_vld,
    output logic [NTHR-1:0]    spu_wen_stacks_ok,
    output logic               spu_wen_allma_stacks_ok,
    output logic [NTHR-1:0]    spu_wen_ma_unc_err_pulse,
    output logic [NTHR-1:0]    spu_wen_ma_unc_err,
    output logic [NTHR-1:0]    spu_wen_ma_cor_err,
    output logic [NTHR-1:0]    spu_wen_cnt_err,
    output logic [122:104]     spu_wen_pckt_req
);

    // Scan enable only matters to the physical scan flops inserted later.
    logic unused_se;
    assign unused_se = se;

    logic [1:0]      l2_err_q;
    logic [NTHR-1:0] maln_wen_q;
    logic [1:0]      vload_tid_q;
    logic            st_asop_q, ld_asop_q;
    logic [1:0]      st_ack_tid_q, ld_ack_tid_q;
    logic            streq_q, streq_qq;
    logic [1:0]      req_tid_q, req_tid_qq;
    logic            st_ackvld_q;
    logic [1:0]      cmplt_q, strm_tid_q;

    // Pipeline stages that align the error, ack and counter inputs with their qualifiers.
    always_ff @(posedge rclk) begin
        if (reset) begin
            l2_err_q     <= '0;
            maln_wen_q   <= '0;
            vload_tid_q  <= '0;
            st_asop_q    <= 1'b0;
            ld_asop_q    <= 1'b0;
            st_ack_tid_q <= '0;
            ld_ack_tid_q <= '0;
            streq_q      <= 1'b0;
            streq_qq     <= 1'b0;
            req_tid_q    <= '0;
            req_tid_qq   <= '0;
            st_ackvld_q  <= 1'b0;
            cmplt_q      <= '0;
            strm_tid_q   <= '0;
        end else begin
            l2_err_q     <= l2_err;
            maln_wen_q   <= spu_wen_maln_wen;
            vload_tid_q  <= lsu_spu_vload_tid;
            st_asop_q    <= lsu_spu_st_asop;
            ld_asop_q    <= lsu_spu_ld_asop;
            st_ack_tid_q <= lsu_spu_st_ack_tid;
            ld_ack_tid_q <= lsu_spu_ld_ack_tid;
            streq_q      <= spu_mactl_streq;
            streq_qq     <= streq_q;
            req_tid_q    <= spu_req_tid;
            req_tid_qq   <= req_tid_q;
            st_ackvld_q  <= lsu_spu_st_ackvld;
            cmplt_q      <= lsu_spu_strm_ack_cmplt;
            strm_tid_q   <= lsu_spu_strm_ack_tid;
        end
    end

    // Line-valid and sticky uncorrectable error; the per-thread clear beats a same-cycle set.
    always_ff @(posedge rclk) begin
        if (reset) begin
            spu_wen_vld_maln   <= '0;
            spu_wen_ma_unc_err <= '0;
        end else begin
            spu_wen_vld_maln   <= (spu_wen_vld_maln | spu_wen_maln_wen) & ~(spu_mald_done | spu_mald_rstln);
            spu_wen_ma_unc_err <= (spu_wen_ma_unc_err | spu_wen_ma_unc_err_pulse) & ~spu_mactl_uncerr_rst;
        end
    end

    for (genvar t = 0; t < NTHR; t++) begin : g_thr
        logic            incr;
        logic [1:0]      decr;
        logic [CNTW+1:0] sum;
        logic [CNTW-1:0] cnt;
        logic            err;

        assign spu_wen_maln_wen[t] = lsu_spu_vload_vld & (lsu_spu_vload_rtntyp == 4'b0010)
                                   & (lsu_spu_vload_tid == 2'(t));

        assign spu_wen_ma_unc_err_pulse[t] = l2_err_q[1] & maln_wen_q[t] & (vload_tid_q == 2'(t));
        assign spu_wen_ma_cor_err[t]       = ~l2_err_q[1] & l2_err_q[0] & maln_wen_q[t]
                                           & (vload_tid_q == 2'(t));

        assign spu_wen_mast_ack[t] = lsu_spu_st_ackvld & st_asop_q & (st_ack_tid_q == 2'(t))
                                   & spu_mactl_streq & (spu_req_tid == 2'(t));
        assign spu_wen_mald_ack[t] = lsu_spu_ld_ackvld & ld_asop_q & (ld_ack_tid_q == 2'(t))
                                   & spu_mald_ldreq & ~spu_mactl_streq & (spu_req_tid == 2'(t));

        assign incr = streq_qq & st_ackvld_q & (req_tid_qq == 2'(t));
        assign decr = (strm_tid_q == 2'(t)) ? cmplt_q : 2'b00;
        // Two extra bits: bit CNTW flags overflow, bit CNTW+1 flags a negative result.
        assign sum  = {2'b00, cnt} + {{(CNTW+1){1'b0}}, incr} - {{CNTW{1'b0}}, decr};

        // Saturating outstanding-store counter with sticky over/underflow flag.
        always_ff @(posedge rclk) begin
            if (reset) begin
                cnt <= '0;
                err <= 1'b0;
            end else if (sum[CNTW+1]) begin
                cnt <= '0;
                err <= 1'b1;
            end else if (sum[CNTW]) begin
                cnt <= '1;
                err <= 1'b1;
            end else begin
                cnt <= sum[CNTW-1:0];
            end
        end

        assign spu_wen_stacks_ok[t] = (cnt == '0);
        assign spu_wen_cnt_err[t]   = err;
    end

    assign spu_wen_allma_stacks_ok = &spu_wen_stacks_ok;
    assign spu_wen_ldst_pcx_vld    = spu_mald_ldreq | spu_mactl_streq;

    // PCX header: request type and size differ between stores and loads.
    always_comb begin
        spu_wen_pckt_req = {6'b001001, cpuid, spu_req_tid, 8'b00000100};
        if (spu_mactl_streq) begin
            spu_wen_pckt_req = {6'b001011, cpuid, spu_req_tid, 8'b00010000};
        end
    end

endmodule

// File: tb/tb_spu_wen_mt.sv
module tb_spu_wen_mt;

    localparam int NTHR = 4;
    localparam int CNTW = 3;

    logic            rclk = 1'b0;
    logic            reset, se;
    logic [2:0]      cpuid;
    logic            ldreq, streq;
    logic [1:0]      req_tid;
    logic            vload_vld;
    logic [3:0]      rtntyp;
    logic [1:0]      vload_tid, l2_err;
    logic            st_ackvld, st_asop, ld_ackvld, ld_asop;
    logic [1:0]      st_ack_tid, ld_ack_tid, cmplt, strm_tid;
    logic [NTHR-1:0] done, rstln, uncerr_rst;
    logic [NTHR-1:0] maln_wen, vld_maln, mast_ack, mald_ack, stacks_ok;
    logic [NTHR-1:0] unc_pulse, unc_err, cor_err, cnt_err;
    logic            pcx_vld, allma_ok;
    logic [122:104]  pckt_req;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 rclk = ~rclk;

    spu_wen_mt #(.NTHR(NTHR), .CNTW(CNTW)) dut (
        .rclk                     (rclk),
        .reset                    (reset),
        .se                       (se),
        .cpuid                    (cpuid),
        .spu_mald_ldreq           (ldreq),
        .spu_mactl_streq          (streq),
        .spu_req_tid              (req_tid),
        .lsu_spu_vload_vld        (vload_vld),
        .lsu_spu_vload_rtntyp     (rtntyp),
        .lsu_spu_vload_tid        (vload_tid),
        .l2_err                   (l2_err),
        .lsu_spu_st_ackvld        (st_ackvld),
        .lsu_spu_st_asop          (st_asop),
        .lsu_spu_st_ack_tid       (st_ack_tid),
        .lsu_spu_ld_ackvld        (ld_ackvld),
        .lsu_spu_ld_asop          (ld_asop),
        .lsu_spu_ld_ack_tid       (ld_ack_tid),
        .lsu_spu_strm_ack_cmplt   (cmplt),
        .lsu_spu_strm_ack_tid     (strm_tid),
        .spu_mald_done            (done),
        .spu_mald_rstln           (rstln),
        .spu_mactl_uncerr_rst     (uncerr_rst),
        .spu_wen_maln_wen         (maln_wen),
        .spu_wen_vld_maln         (vld_maln),
        .spu_wen_mast_ack         (mast_ack),
        .spu_wen_mald_ack         (mald_ack),
        .spu_wen_ldst_pcx_vld     (pcx_vld),
        .spu_wen_stacks_ok        (stacks_ok),
        .spu_wen_allma_stacks_ok  (allma_ok),
        .spu_wen_ma_unc_err_pulse (unc_pulse),
        .spu_wen_ma_unc_err       (unc_err),
        .spu_wen_ma_cor_err       (cor_err),
        .spu_wen_cnt_err          (cnt_err),
        .spu_wen_pckt_req         (pckt_req)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and checks happen 1 time unit after the rising edge.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic idle_inputs();
        ldreq = 0; streq = 0; req_tid = 0;
        vload_vld = 0; rtntyp = 0; vload_tid = 0; l2_err = 0;
        st_ackvld = 0; st_asop = 0; st_ack_tid = 0;
        ld_ackvld = 0; ld_asop = 0; ld_ack_tid = 0;
        cmplt = 0; strm_tid = 0;
        done = 0; rstln = 0; uncerr_rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        se = 0; cpuid = 0; reset = 1;
        idle_inputs();
        repeat (3) tick();
        reset = 0;
        tick();
        #1;
        chk("rst_stacks_ok", 32'(stacks_ok), 32'hF);
        chk("rst_allma_ok", 32'(allma_ok), 32'h1);
        chk("rst_vld_maln", 32'(vld_maln), 32'h0);
        chk("rst_cnt_err", 32'(cnt_err), 32'h0);
        chk("rst_unc_err", 32'(unc_err), 32'h0);
        chk("rst_pcx_vld", 32'(pcx_vld), 32'h0);

        // Load return on thread 2 with uncorrectable error.
        vload_vld = 1; rtntyp = 4'b0010; vload_tid = 2; l2_err = 2'b10;
        #1;
        chk("wen_t2", 32'(maln_wen), 32'h4);
        tick();
        vload_vld = 0; l2_err = 0; vload_tid = 0;
        #1;
        chk("vld_maln_t2", 32'(vld_maln), 32'h4);
        chk("unc_pulse_t2", 32'(unc_pulse), 32'h4);
        chk("cor_err_none", 32'(cor_err), 32'h0);
        tick();
        chk("unc_err_set", 32'(unc_err), 32'h4);
        chk("unc_pulse_gone", 32'(unc_pulse), 32'h0);
        tick();
        chk("unc_err_sticky", 32'(unc_err), 32'h4);
        uncerr_rst = 4'b0100; rstln = 4'b0100;
        tick();
        uncerr_rst = 0; rstln = 0;
        #1;
        chk("unc_err_clr", 32'(unc_err), 32'h0);
        chk("vld_maln_rstln", 32'(vld_maln), 32'h0);

        // Correctable error on thread 1.
        vload_vld = 1; rtntyp = 4'b0010; vload_tid = 1; l2_err = 2'b01;
        tick();
        vload_vld = 0; l2_err = 0; vload_tid = 0;
        #1;
        chk("cor_err_t1", 32'(cor_err), 32'h2);
        chk("unc_pulse_cor", 32'(unc_pulse), 32'h0);
        chk("vld_maln_t1", 32'(vld_maln), 32'h2);

        // Non-load return type is ignored; done[1] clears line 1 meanwhile.
        vload_vld = 1; rtntyp = 4'b0011; vload_tid = 2; l2_err = 2'b10; done = 4'b0010;
        #1;
        chk("wen_bad_type", 32'(maln_wen), 32'h0);
        tick();
        vload_vld = 0; l2_err = 0; done = 0;
        #1;
        chk("vld_bad_type", 32'(vld_maln), 32'h0);
        chk("pulse_bad_type", 32'(unc_pulse), 32'h0);

        // Clear wins over set on the same cycle.
        vload_vld = 1; rtntyp = 4'b0010; vload_tid = 0; done = 4'b0001;
        #1;
        chk("wen_t0", 32'(maln_wen), 32'h1);
        tick();
        vload_vld = 0; done = 0;
        #1;
        chk("vld_clr_wins", 32'(vld_maln), 32'h0);

        // Single store on thread 1, ack one cycle later.
        streq = 1; req_tid = 1;
        #1;
        chk("pcx_vld_st", 32'(pcx_vld), 32'h1);
        chk("pckt_st_t1", 32'(pckt_req), 32'(19'b001011_000_01_00010000));
        tick();
        streq = 0; st_ackvld = 1;
        tick();
        st_ackvld = 0;
        #1;
        chk("cnt1_not_yet", 32'(stacks_ok), 32'hF);
        tick();
        chk("cnt1_one", 32'(stacks_ok), 32'hD);
        chk("allma_busy", 32'(allma_ok), 32'h0);
        cmplt = 2'b01; strm_tid = 1;
        tick();
        cmplt = 0; strm_tid = 0;
        #1;
        chk("cnt1_dec_pend", 32'(stacks_ok), 32'hD);
        tick();
        chk("cnt1_zero", 32'(stacks_ok), 32'hF);
        chk("cnt1_no_err", 32'(cnt_err), 32'h0);

        // Thread 0: three stores, then a fourth store ack alongside cmplt=2 -> net count 2.
        for (int i = 0; i < 6; i++) begin
            streq = (i < 4); req_tid = 0;
            st_ackvld = (i >= 1 && i <= 4);
            cmplt = (i == 4) ? 2'd2 : 2'd0; strm_tid = 0;
            tick();
        end
        idle_inputs();
        #1;
        chk("cnt0_net", 32'(stacks_ok), 32'hE);
        cmplt = 2; strm_tid = 0;
        tick();
        cmplt = 0;
        tick();
        chk("cnt0_two_gone", 32'(stacks_ok), 32'hF);
        chk("cnt0_no_err", 32'(cnt_err), 32'h0);
        cmplt = 2; strm_tid = 0;
        tick();
        cmplt = 0;
        tick();
        chk("cnt0_underflow_ok", 32'(stacks_ok), 32'hF);
        chk("cnt0_underflow_err", 32'(cnt_err), 32'h1);

        // Load ack on thread 2, then store on the same cycle blocks it.
        cpuid = 3'd5; ld_asop = 1; ld_ack_tid = 2;
        tick();
        ld_ackvld = 1; ldreq = 1; req_tid = 2;
        #1;
        chk("mald_ack_t2", 32'(mald_ack), 32'h4);
        chk("pckt_ld_t2", 32'(pckt_req), 32'(19'b001001_101_10_00000100));
        streq = 1;
        #1;
        chk("mald_ack_blocked", 32'(mald_ack), 32'h0);
        chk("pckt_st_t2", 32'(pckt_req), 32'(19'b001011_101_10_00010000));
        chk("mast_ack_noack", 32'(mast_ack), 32'h0);
        tick();
        idle_inputs();
        repeat (3) tick();

        // Thread 3: eight acked stores overflow the 3-bit counter; first ack is also an MA store ack.
        st_asop = 1; st_ack_tid = 3;
        for (int i = 0; i < 9; i++) begin
            streq = (i < 8); req_tid = 3;
            st_ackvld = (i >= 1);
            #1;
            if (i == 1) chk("mast_ack_t3", 32'(mast_ack), 32'h8);
            tick();
        end
        idle_inputs();
        repeat (2) tick();
        chk("cnt3_sat_busy", 32'(stacks_ok), 32'h7);
        chk("cnt3_sat_err", 32'(cnt_err), 32'h9);
        for (int j = 0; j < 3; j++) begin
            cmplt = 2; strm_tid = 3;
            tick();
        end
        cmplt = 0;
        tick();
        chk("cnt3_one_left", 32'(stacks_ok), 32'h7);
        cmplt = 1; strm_tid = 3;
        tick();
        cmplt = 0;
        tick();
        chk("cnt3_empty", 32'(stacks_ok), 32'hF);
        chk("cnt3_allma", 32'(allma_ok), 32'h1);
        chk("cnt3_err_kept", 32'(cnt_err), 32'h9);

        // Store in flight when reset arrives: ack lands during reset and is dropped.
        streq = 1; req_tid = 1;
        tick();
        streq = 0; st_ackvld = 1; reset = 1;
        tick();
        st_ackvld = 1; reset = 0;
        tick();
        st_ackvld = 0;
        repeat (3) tick();
        chk("rst_mid_stacks", 32'(stacks_ok), 32'hF);
        chk("rst_mid_err", 32'(cnt_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
